alu_matrix_sequencer: RTL and testbench
=======================================

Name: alu_matrix_sequencer

Overview:
- Command-level controller in front of ALUMatrixTop; the matrix core itself is unchanged.
- Accepts one operation command plus a stream of operand elements.
- Drives the core's sel/eleIn bus to load A, B and scalar, holds the operation code for the required cycles, then reads results back as a valid/ready stream.
- Lets software or a host FSM use the matrix ALU without hand-timing sel codes.

Parameters:
- OP_CYCLES, 2, cycles the op code is held for transpose/add/sub/scalar/det.
- MULT_CYCLES, 6, cycles the op code is held for A*B.
- PARK_SEL, 6'd63, no-op sel code driven whenever the core is not being addressed.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  3  0 transpose, 1 A+B, 2 A-B, 3 A*B, 4 k*A, 5 det(A), 6/7 illegal
- cmd_keep  in  1  1 = skip operand loading and reuse resident A/B
- cmd_scalar  in  32  k for op 4, captured at command accept
- in_valid / in_ready  in/out  1/1  operand element stream, row-major, A then B
- in_data  in  32  operand element
- out_valid / out_ready  out/in  1/1  result element stream
- out_data  out  32  result element
- out_last  out  1  high with the final result beat
- busy  out  1  state != IDLE
- err  out  1  one-cycle pulse on illegal op accept
- mat_sel  out  6  registered, to core sel
- mat_ele_in  out  32  registered, to core eleIn
- mat_ele_out  in  32  from core eleOut, combinational read

Behaviour:
- Reset (async, any state) -> IDLE.
  - mat_sel = PARK_SEL; mat_ele_in, out_data = 0.
  - out_valid, out_last, err, busy, in_ready = 0; cmd_ready = 1.
  - Element counters = 0.
- Command accept: cmd_valid & cmd_ready.
  - Latches op, keep, scalar.
  - Illegal op: err pulses next cycle and the block stays in IDLE.
- State transitions:
  - IDLE -> LOAD_A, or -> LOAD_K/EXEC if keep.
  - LOAD_A (9 beats) -> LOAD_B.
  - LOAD_B (9 beats, only for ops 1-3) -> LOAD_K or EXEC.
  - LOAD_K (op 4 only; one cycle: mat_sel = 40, mat_ele_in = scalar) -> EXEC.
  - EXEC -> RD_SEL -> RD_CAP -> RD_OUT; RD_OUT loops to RD_SEL or returns to IDLE.
- Load phases:
  - in_ready = 1 in LOAD_A/LOAD_B.
  - Each accepted beat registers mat_sel = idx (A: 0-8, B: 9-17) and mat_ele_in = in_data; these are visible the next cycle.
  - A cycle with no beat registers mat_sel = PARK_SEL. Stalls are unbounded.
- EXEC:
  - mat_sel = op code (28/29/30/31/32/33) for OP_CYCLES, or MULT_CYCLES for op 3.
  - Then PARK_SEL.
- Read phase (9 elements, sel 18-26; det reads 1 element, sel 27):
  - RD_SEL registers mat_sel = code.
  - RD_CAP samples mat_ele_out into out_data and sets out_valid.
  - RD_OUT holds out_data stable while out_valid & !out_ready.
  - On handshake: out_valid drops.
    - If more elements remain, go to RD_SEL with the next index.
    - Otherwise go to IDLE; out_last was high with that beat.
  - Minimum 3 cycles per result beat.
- mat_sel never changes within RD_OUT.
- in_ready = 0 outside load states; out_valid = 0 outside RD_OUT.
- Counters: 4-bit, compared against 8 (or 0 for det); no wrap beyond the last index.
- A new cmd_valid during busy is ignored (cmd_ready low); the command is not lost and is accepted on return to IDLE.
- Data is passed unmodified: no width change, signedness is the consumer's concern.

Test Plan:
- Add, A = B = 0..8: mat_sel trace 0..17 with eleIn = 0..8 twice, 29 held 2 cycles; out stream 0,2,4,...,16, out_last on 9th beat.
- Multiply with the same matrices: 31 held 6 cycles; out 15,18,21,42,54,66,69,90,111.
- Transpose with cmd_keep = 1: no in_ready, out 0,3,6,1,4,7,2,5,8. Then scalar with k = 2: sel 40 with eleIn = 2 precedes 32; out 0,2,4,...,16.
- Det, A = [0 2 2; 3 4 8; 6 17 18]: single beat, signed value 42, out_last = 1. Same for A = 0..8: output 0.
- Backpressure/stall: random gaps on in_valid and out_ready -> identical results, out_data stable while stalled, PARK_SEL during input gaps.
- Reset asserted mid-LOAD_B and mid-RD_OUT: outputs return to reset values immediately, cmd_ready = 1. Illegal op 6: err pulse, no mat_sel activity.

Source files
------------

// File: rtl/alu_matrix_sequencer.sv
// alu_matrix_sequencer
// Command-level front end for the 3x3 matrix ALU core. Takes one operation
// command and a row-major operand stream, walks the core's sel/eleIn bus
// through load, execute and read-back, and presents the results as a
// valid/ready stream with a last-beat marker.
module alu_matrix_sequencer #(
   parameter int unsigned OP_CYCLES   = 2,
   parameter int unsigned MULT_CYCLES = 6,
   parameter logic [5:0]  PARK_SEL    = 6'd63
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic        cmd_keep,
   input  logic [31:0] cmd_scalar,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_last,
   output logic        busy,
   output logic        err,
   output logic [5:0]  mat_sel,
   output logic [31:0] mat_ele_in,
   input  logic [31:0] mat_ele_out
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_A,
      S_LOAD_B,
      S_LOAD_K,
      S_EXEC,
      S_RD_SEL,
      S_RD_CAP,
      S_RD_OUT
   } state_t;

   localparam logic [2:0] OP_TRANS  = 3'd0;
   localparam logic [2:0] OP_MUL    = 3'd3;
   localparam logic [2:0] OP_SCALAR = 3'd4;
   localparam logic [2:0] OP_DET    = 3'd5;

   localparam logic [5:0] SEL_B_BASE = 6'd9;
   localparam logic [5:0] SEL_R_BASE = 6'd18;
   localparam logic [5:0] SEL_DET    = 6'd27;
   localparam logic [5:0] SEL_OP_BASE = 6'd28;
   localparam logic [5:0] SEL_SCALAR = 6'd40;

   localparam logic [3:0] LAST_ELEM = 4'd8;
   localparam logic [7:0] OP_LEN    = 8'(OP_CYCLES);
   localparam logic [7:0] MULT_LEN  = 8'(MULT_CYCLES);

   state_t      state_q;
   logic [2:0]  op_q;
   logic [31:0] scalar_q;
   logic [3:0]  elem_q;
   logic [7:0]  exec_q;
   logic [5:0]  sel_q;
   logic [31:0] ele_in_q;
   logic [31:0] out_data_q;
   logic        out_valid_q;
   logic        out_last_q;
   logic        err_q;

   logic [5:0]  op_code_d;
   logic [3:0]  last_idx_d;
   logic [7:0]  exec_len_d;
   logic        needs_b_d;

   // Per-command decode of the latched op: core op code, read length,
   // execute hold time and whether a B operand is loaded.
   always_comb begin
      op_code_d  = SEL_OP_BASE + {3'b000, op_q};
      last_idx_d = (op_q == OP_DET) ? 4'd0 : LAST_ELEM;
      exec_len_d = (op_q == OP_MUL) ? MULT_LEN : OP_LEN;
      needs_b_d  = (op_q != OP_TRANS) && (op_q <= OP_MUL);
   end

   // Handshake flags are pure decodes of the registered state.
   always_comb begin
      cmd_ready = (state_q == S_IDLE);
      busy      = (state_q != S_IDLE);
      in_ready  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_last   = out_last_q;
   assign err        = err_q;
   assign mat_sel    = sel_q;
   assign mat_ele_in = ele_in_q;

   // Sequencer FSM: all core-facing and stream-facing outputs registered here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         scalar_q    <= '0;
         elem_q      <= '0;
         exec_q      <= '0;
         sel_q       <= PARK_SEL;
         ele_in_q    <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               sel_q <= PARK_SEL;
               if (cmd_valid) begin
                  op_q     <= cmd_op;
                  scalar_q <= cmd_scalar;
                  elem_q   <= '0;
                  exec_q   <= '0;
                  if (cmd_op > OP_DET) begin
                     err_q <= 1'b1;
                  end else if (!cmd_keep) begin
                     state_q <= S_LOAD_A;
                  end else if (cmd_op == OP_SCALAR) begin
                     state_q <= S_LOAD_K;
                  end else begin
                     state_q <= S_EXEC;
                  end
               end
            end

            S_LOAD_A: begin
               if (in_valid) begin
                  sel_q    <= {2'b00, elem_q};
                  ele_in_q <= in_data;
                  if (elem_q == LAST_ELEM) begin
                     elem_q <= '0;
                     if (needs_b_d) begin
                        state_q <= S_LOAD_B;
                     end else if (op_q == OP_SCALAR) begin
                        state_q <= S_LOAD_K;
                     end else begin
                        state_q <= S_EXEC;
                     end
                  end else begin
                     elem_q <= elem_q + 4'd1;
                  end
               end else begin
                  sel_q <= PARK_SEL;
               end
            end

            S_LOAD_B: begin
               if (in_valid) begin
                  sel_q    <= SEL_B_BASE + {2'b00, elem_q};
                  ele_in_q <= in_data;
                  if (elem_q == LAST_ELEM) begin
                     elem_q  <= '0;
                     state_q <= S_EXEC;
                  end else begin
                     elem_q <= elem_q + 4'd1;
                  end
               end else begin
                  sel_q <= PARK_SEL;
               end
            end

            S_LOAD_K: begin
               sel_q    <= SEL_SCALAR;
               ele_in_q <= scalar_q;
               state_q  <= S_EXEC;
            end

            // The first EXEC cycle only registers the op code, so the code is
            // visible on mat_sel for exactly exec_len_d cycles before parking.
            S_EXEC: begin
               if (exec_q == exec_len_d) begin
                  sel_q   <= PARK_SEL;
                  exec_q  <= '0;
                  elem_q  <= '0;
                  state_q <= S_RD_SEL;
               end else begin
                  sel_q  <= op_code_d;
                  exec_q <= exec_q + 8'd1;
               end
            end

            S_RD_SEL: begin
               sel_q   <= (op_q == OP_DET) ? SEL_DET : (SEL_R_BASE + {2'b00, elem_q});
               state_q <= S_RD_CAP;
            end

            S_RD_CAP: begin
               out_data_q  <= mat_ele_out;
               out_valid_q <= 1'b1;
               out_last_q  <= (elem_q == last_idx_d);
               state_q     <= S_RD_OUT;
            end

            S_RD_OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  if (elem_q == last_idx_d) begin
                     sel_q   <= PARK_SEL;
                     elem_q  <= '0;
                     state_q <= S_IDLE;
                  end else begin
                     elem_q  <= elem_q + 4'd1;
                     state_q <= S_RD_SEL;
                  end
               end
            end

            default: begin
               state_q <= S_IDLE;
               sel_q   <= PARK_SEL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_matrix_sequencer.sv
// Testbench for alu_matrix_sequencer with a behavioural model of the matrix
// core on the sel/eleIn/eleOut bus and queue-based scoreboards for the
// result stream and the load-phase sel trace.
module tb_alu_matrix_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic        cmd_keep;
   logic [31:0] cmd_scalar;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;
   logic        busy;
   logic        err;
   logic [5:0]  mat_sel;
   logic [31:0] mat_ele_in;
   logic [31:0] mat_ele_out;

   always #5 clk = ~clk;

   alu_matrix_sequencer #(
      .OP_CYCLES   (2),
      .MULT_CYCLES (6),
      .PARK_SEL    (6'd63)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_keep    (cmd_keep),
      .cmd_scalar  (cmd_scalar),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .busy        (busy),
      .err         (err),
      .mat_sel     (mat_sel),
      .mat_ele_in  (mat_ele_in),
      .mat_ele_out (mat_ele_out)
   );

   // ---------------- matrix core model ----------------
   logic [31:0] ca [9];
   logic [31:0] cb [9];
   logic [31:0] cr [9];
   logic [31:0] ck;
   logic [31:0] cdet;

   function automatic logic [31:0] mul_el(input int r, input int c);
      return ca[r*3]*cb[c] + ca[r*3+1]*cb[3+c] + ca[r*3+2]*cb[6+c];
   endfunction

   function automatic logic [31:0] det_a();
      int a [9];
      for (int i = 0; i < 9; i++) a[i] = int'(ca[i]);
      return 32'(a[0]*(a[4]*a[8]-a[5]*a[7]) - a[1]*(a[3]*a[8]-a[5]*a[6])
                 + a[2]*(a[3]*a[7]-a[4]*a[6]));
   endfunction

   always @(posedge clk) begin : core_model
      int s;
      s = int'(mat_sel);
      if (s < 9) ca[s] <= mat_ele_in;
      else if (s < 18) cb[s-9] <= mat_ele_in;
      case (s)
         28: for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) cr[r*3+c] <= ca[c*3+r];
         29: for (int i = 0; i < 9; i++) cr[i] <= ca[i] + cb[i];
         30: for (int i = 0; i < 9; i++) cr[i] <= ca[i] - cb[i];
         31: for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) cr[r*3+c] <= mul_el(r, c);
         32: for (int i = 0; i < 9; i++) cr[i] <= ck * ca[i];
         33: cdet <= det_a();
         40: ck <= mat_ele_in;
         default: ;
      endcase
   end

   assign mat_ele_out = (mat_sel >= 6'd18 && mat_sel <= 6'd26) ? cr[int'(mat_sel) - 18] :
                        (mat_sel == 6'd27) ? cdet : 32'd0;

   // ---------------- scoreboard state ----------------
   logic [32:0] exp_q [$];     // {last, data}
   logic [37:0] trace_q [$];   // {sel, eleIn}
   int total = 0;
   int bad = 0;
   int code_cycles = 0;
   int inrdy_cycles = 0;
   int err_cycles = 0;
   logic [5:0]  last_code = 6'd0;
   logic [5:0]  pre_code_sel = 6'd0;
   logic [5:0]  prev_sel = 6'd63;
   logic        stalled = 1'b0;
   logic [31:0] held_data = 32'd0;
   logic        held_last = 1'b0;
   int out_mode = 0;           // 0 ready, 1 random, 2 never
   int expo [9];
   int mat_a [9];
   int mat_b [9];

   task automatic chk(input string nm, input longint got, input longint req);
      total++;
      if (got !== req) begin
         bad++;
         $display("FAIL %s: got %0d required %0d", nm, got, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic monitor();
      logic [32:0] e;
      logic [37:0] t;
      forever begin
         @(negedge clk);
         if (reset) begin
            stalled  = 1'b0;
            prev_sel = 6'd63;
         end else begin
            if (stalled && out_valid) begin
               chk("stall_data", out_data, held_data);
               chk("stall_last", out_last, held_last);
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL out_extra: got beat %0d required none", out_data);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_data", out_data, e[31:0]);
                  chk("out_last", out_last, e[32]);
               end
            end
            stalled   = out_valid && !out_ready;
            held_data = out_data;
            held_last = out_last;
            if (mat_sel < 6'd18 || mat_sel == 6'd40) begin
               if (trace_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL trace_extra: got sel %0d required none", mat_sel);
               end else begin
                  t = trace_q.pop_front();
                  chk("trace_sel", mat_sel, t[37:32]);
                  chk("trace_ele", mat_ele_in, t[31:0]);
               end
            end
            if (mat_sel >= 6'd28 && mat_sel <= 6'd33) begin
               code_cycles++;
               last_code = mat_sel;
               if (!(prev_sel >= 6'd28 && prev_sel <= 6'd33)) pre_code_sel = prev_sel;
            end
            if (in_ready) inrdy_cycles++;
            if (err) err_cycles++;
            prev_sel = mat_sel;
         end
      end
   endtask

   task automatic ready_driver();
      forever begin
         @(posedge clk);
         #1;
         out_ready = (out_mode == 0) ? 1'b1 : (out_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      end
   endtask

   task automatic issue(input int op, input int keep, input int k);
      int n;
      cmd_op     = 3'(op);
      cmd_keep   = 1'(keep);
      cmd_scalar = 32'(k);
      cmd_valid  = 1'b1;
      n = 0;
      while (!cmd_ready && n < 200) begin
         tick();
         n++;
      end
      if (n == 200) chk("cmd_accept_timeout", 0, 1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic feed(input int sel, input int val, input int gapmax);
      int n;
      int g;
      g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
      repeat (g) tick();
      in_valid = 1'b1;
      in_data  = 32'(val);
      n = 0;
      while (!in_ready && n < 200) begin
         tick();
         n++;
      end
      if (n == 200) chk("in_ready_timeout", 0, 1);
      trace_q.push_back({6'(sel), 32'(val)});
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || exp_q.size() != 0) && n < 3000) begin
         tick();
         n++;
      end
      if (n == 3000) chk("idle_timeout", 0, 1);
      tick();
      chk("trace_left", trace_q.size(), 0);
   endtask

   task automatic run_cmd(input int op, input int keep, input int k, input int hold,
                          input int nout, input int gapmax);
      int base_code;
      int base_in;
      base_code = code_cycles;
      base_in   = inrdy_cycles;
      for (int i = 0; i < nout; i++) exp_q.push_back({1'(i == nout - 1), 32'(expo[i])});
      issue(op, keep, k);
      if (!keep) begin
         for (int i = 0; i < 9; i++) feed(i, mat_a[i], gapmax);
         if (op >= 1 && op <= 3)
            for (int i = 0; i < 9; i++) feed(9 + i, mat_b[i], gapmax);
      end
      if (op == 4) trace_q.push_back({6'd40, 32'(k)});
      wait_idle();
      chk("code_hold", code_cycles - base_code, hold);
      chk("code_value", last_code, 28 + op);
      if (keep) chk("keep_no_in_ready", inrdy_cycles - base_in, 0);
      if (op == 4) chk("scalar_before_code", pre_code_sel, 40);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_last"}, out_last, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_mat_sel"}, mat_sel, 63);
      chk({tag, "_mat_ele_in"}, mat_ele_in, 0);
      chk({tag, "_out_data"}, out_data, 0);
   endtask

   task automatic set_seq(output int m [9], input int base, input int step);
      for (int i = 0; i < 9; i++) m[i] = base + step * i;
   endtask

   task automatic stimulus();
      int n;
      int base_err;
      int base_code;
      int mexp [9];
      int dmat [9];
      mexp = '{15, 18, 21, 42, 54, 66, 69, 90, 111};
      dmat = '{0, 2, 2, 3, 4, 8, 6, 17, 18};

      reset = 1'b1;
      repeat (3) tick();
      check_reset_outputs("rst0");
      reset = 1'b0;
      tick();

      // A + B with A = B = 0..8
      set_seq(mat_a, 0, 1);
      set_seq(mat_b, 0, 1);
      set_seq(expo, 0, 2);
      run_cmd(1, 0, 0, 2, 9, 0);

      // A * B with the same matrices
      expo = mexp;
      run_cmd(3, 0, 0, 6, 9, 0);

      // transpose on resident A
      expo = '{0, 3, 6, 1, 4, 7, 2, 5, 8};
      run_cmd(0, 1, 0, 2, 9, 0);

      // k * A with k = 2 on resident A
      set_seq(expo, 0, 2);
      run_cmd(4, 1, 2, 2, 9, 0);

      // determinants
      mat_a = dmat;
      expo[0] = 42;
      run_cmd(5, 0, 0, 2, 1, 0);
      set_seq(mat_a, 0, 1);
      expo[0] = 0;
      run_cmd(5, 0, 0, 2, 1, 0);

      // A - B and A + B under input gaps and output backpressure
      out_mode = 1;
      set_seq(mat_a, 10, 1);
      set_seq(mat_b, 0, 1);
      set_seq(expo, 10, 0);
      run_cmd(2, 0, 0, 2, 9, 3);
      set_seq(mat_a, 0, 1);
      set_seq(expo, 0, 2);
      run_cmd(1, 0, 0, 2, 9, 3);
      out_mode = 0;

      // illegal op: err pulse only
      base_err  = err_cycles;
      base_code = code_cycles;
      issue(6, 0, 0);
      repeat (4) tick();
      chk("illegal_err_pulse", err_cycles - base_err, 1);
      chk("illegal_busy", busy, 0);
      chk("illegal_no_exec", code_cycles - base_code, 0);
      chk("illegal_trace", trace_q.size(), 0);

      // reset mid-LOAD_B
      issue(1, 0, 0);
      for (int i = 0; i < 9; i++) feed(i, i, 0);
      for (int i = 0; i < 4; i++) feed(9 + i, i, 0);
      repeat (2) tick();
      chk("midload_busy", busy, 1);
      reset = 1'b1;
      #1;
      check_reset_outputs("rst_load");
      tick();
      reset = 1'b0;
      exp_q.delete();
      trace_q.delete();
      tick();

      // reset mid-RD_OUT with the result held
      out_mode = 2;
      issue(0, 1, 0);
      n = 0;
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
      chk("rdout_reached", out_valid, 1);
      repeat (3) tick();
      reset = 1'b1;
      #1;
      check_reset_outputs("rst_rd");
      tick();
      reset = 1'b0;
      exp_q.delete();
      trace_q.delete();
      out_mode = 0;
      tick();

      // recovery after reset
      set_seq(mat_a, 1, 1);
      set_seq(mat_b, 1, 1);
      set_seq(expo, 2, 2);
      run_cmd(1, 0, 0, 2, 9, 0);
   endtask

   initial begin
      reset      = 1'b1;
      cmd_valid  = 1'b0;
      cmd_op     = '0;
      cmd_keep   = 1'b0;
      cmd_scalar = '0;
      in_valid   = 1'b0;
      in_data    = '0;
      out_ready  = 1'b1;
      fork
         monitor();
         ready_driver();
         stimulus();
      join_any
      disable fork;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
